// File: rtl/alu_issue_stage.sv
// MIPS ALU issue stage: decodes one instruction into registered ALU operands, 1-cycle latency.
// Valid/ready output held while outReady is low; flush drops the held entry and blocks input.
module alu_issue_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrIn,
    input  logic [31:0] rsValue,
    input  logic [31:0] rtValue,
    input  logic        inValid,
    output logic        inReady,
    input  logic        flush,
    input  logic        outReady,
    output logic        outValid,
    output logic [31:0] operandOneALU,
    output logic [31:0] operandTwoALU,
    output logic [3:0]  ControlValueALU,
    output logic [4:0]  destReg,
    output logic        regWrite,
    output logic [7:0]  illegalCount
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1010;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  dest;
        logic        wr;
    } issue_t;

    issue_t      dec;
    issue_t      issue_q, issue_d;
    logic        valid_q, valid_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        legal, nop, xfer;
    logic [5:0]  opcode, funct;
    logic [31:0] imm_sext, imm_zext;

    assign opcode   = instrIn[31:26];
    assign funct    = instrIn[5:0];
    assign imm_sext = {{16{instrIn[15]}}, instrIn[15:0]};
    assign imm_zext = {16'h0000, instrIn[15:0]};
    assign nop      = (instrIn == 32'h0);

    always_comb begin
        dec   = '0;
        legal = 1'b0;
        case (opcode)
            6'h00: begin
                dec.op1  = rsValue;
                dec.op2  = rtValue;
                dec.dest = instrIn[15:11];
                dec.wr   = 1'b1;
                legal    = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec.ctrl = ALU_ADD;
                    6'h22, 6'h23: dec.ctrl = ALU_SUB;
                    6'h24:        dec.ctrl = ALU_AND;
                    6'h25:        dec.ctrl = ALU_OR;
                    6'h27:        dec.ctrl = ALU_NOR;
                    6'h2A:        dec.ctrl = ALU_SLT;
                    6'h02: begin
                        dec.ctrl = ALU_SRL;
                        dec.op1  = rtValue;
                        dec.op2  = {27'h0, instrIn[10:6]};
                    end
                    default:      legal = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23: begin
                dec.op1  = rsValue;
                dec.op2  = imm_sext;
                dec.dest = instrIn[20:16];
                dec.wr   = 1'b1;
                legal    = 1'b1;
                case (opcode)
                    6'h0A:   dec.ctrl = ALU_SLT;
                    6'h0C: begin dec.ctrl = ALU_AND; dec.op2 = imm_zext; end
                    6'h0D: begin dec.ctrl = ALU_OR;  dec.op2 = imm_zext; end
                    6'h0F: begin dec.ctrl = ALU_LUI; dec.op2 = imm_zext; dec.op1 = '0; end
                    default: dec.ctrl = ALU_ADD;
                endcase
            end
            6'h2B: begin
                dec.ctrl = ALU_ADD;
                dec.op1  = rsValue;
                dec.op2  = imm_sext;
                legal    = 1'b1;
            end
            6'h04: begin
                dec.ctrl = ALU_SUB;
                dec.op1  = rsValue;
                dec.op2  = rtValue;
                legal    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign inReady = (!valid_q || outReady) && !flush;
    assign xfer    = inValid && inReady;

    // NOPs and illegal instructions are consumed but leave the output slot empty.
    always_comb begin
        valid_d = valid_q;
        issue_d = issue_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (xfer) begin
            valid_d = legal && !nop;
            if (legal && !nop) begin
                issue_d = dec;
            end
            if (!legal && !nop && (cnt_q != 8'hFF)) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (valid_q && outReady) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            issue_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            issue_q <= issue_d;
            cnt_q   <= cnt_d;
        end
    end

    assign outValid        = valid_q;
    assign operandOneALU   = issue_q.op1;
    assign operandTwoALU   = issue_q.op2;
    assign ControlValueALU = issue_q.ctrl;
    assign destReg         = issue_q.dest;
    assign regWrite        = issue_q.wr;
    assign illegalCount    = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: decode vector table, stall/flush/saturation/async-reset
// sequences, then random traffic against a reference model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instrIn = '0, rsValue = '0, rtValue = '0;
    logic        inValid = 1'b0, flush = 1'b0, outReady = 1'b0;
    logic        inReady, outValid, regWrite;
    logic [31:0] operandOneALU, operandTwoALU;
    logic [3:0]  ControlValueALU;
    logic [4:0]  destReg;
    logic [7:0]  illegalCount;

    alu_issue_stage dut (
        .clk(clk), .reset(reset), .instrIn(instrIn), .rsValue(rsValue), .rtValue(rtValue),
        .inValid(inValid), .inReady(inReady), .flush(flush), .outReady(outReady),
        .outValid(outValid), .operandOneALU(operandOneALU), .operandTwoALU(operandTwoALU),
        .ControlValueALU(ControlValueALU), .destReg(destReg), .regWrite(regWrite),
        .illegalCount(illegalCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic [31:0] instr, rs, rt;
        logic        vld;
        logic [3:0]  ctrl;
        logic [31:0] op1, op2;
        logic [4:0]  dest;
        logic        wr;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic [1:0]  kind;   // 0 nop, 1 illegal, 2 legal
        logic [3:0]  ctrl;
        logic [31:0] op1, op2;
        logic [4:0]  dest;
        logic        wr;
    } ref_t;

    function automatic ref_t ref_dec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        ref_t r;
        logic [5:0] op, fn;
        logic [31:0] se, ze;
        op = ins[31:26];
        fn = ins[5:0];
        se = 32'($signed(ins[15:0]));
        ze = 32'(ins[15:0]);
        r = '0;
        r.kind = 2'd2;
        if (ins == 32'h0) r.kind = 2'd0;
        else if (op == 6'h00) begin
            r.op1 = a; r.op2 = b; r.dest = ins[15:11]; r.wr = 1'b1;
            if (fn == 6'h20 || fn == 6'h21) r.ctrl = 4'b0010;
            else if (fn == 6'h22 || fn == 6'h23) r.ctrl = 4'b0110;
            else if (fn == 6'h24) r.ctrl = 4'b0000;
            else if (fn == 6'h25) r.ctrl = 4'b0001;
            else if (fn == 6'h27) r.ctrl = 4'b1010;
            else if (fn == 6'h2A) r.ctrl = 4'b0111;
            else if (fn == 6'h02) begin r.ctrl = 4'b1001; r.op1 = b; r.op2 = 32'(ins[10:6]); end
            else r.kind = 2'd1;
        end
        else if (op == 6'h08 || op == 6'h09 || op == 6'h23) begin r.ctrl = 4'b0010; r.op1 = a; r.op2 = se; r.dest = ins[20:16]; r.wr = 1'b1; end
        else if (op == 6'h0A) begin r.ctrl = 4'b0111; r.op1 = a; r.op2 = se; r.dest = ins[20:16]; r.wr = 1'b1; end
        else if (op == 6'h0C) begin r.ctrl = 4'b0000; r.op1 = a; r.op2 = ze; r.dest = ins[20:16]; r.wr = 1'b1; end
        else if (op == 6'h0D) begin r.ctrl = 4'b0001; r.op1 = a; r.op2 = ze; r.dest = ins[20:16]; r.wr = 1'b1; end
        else if (op == 6'h0F) begin r.ctrl = 4'b1000; r.op1 = 0; r.op2 = ze; r.dest = ins[20:16]; r.wr = 1'b1; end
        else if (op == 6'h2B) begin r.ctrl = 4'b0010; r.op1 = a; r.op2 = se; r.wr = 1'b0; end
        else if (op == 6'h04) begin r.ctrl = 4'b0110; r.op1 = a; r.op2 = b; r.wr = 1'b0; end
        else r.kind = 2'd1;
        return r;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [5:0] fns [9];
        logic [5:0] ops [9];
        int sel;
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h02};
        ops = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04};
        w = $urandom;
        sel = $urandom_range(0, 9);
        if (sel == 0) w = 32'h0;
        else if (sel <= 3) begin w[31:26] = 6'h00; w[5:0] = fns[$urandom_range(0, 8)]; end
        else if (sel == 4) w[31:26] = 6'h00;
        else if (sel <= 7) w[31:26] = ops[$urandom_range(0, 8)];
        return w;
    endfunction

    task automatic do_reset();
        inValid = 1'b0; flush = 1'b0; outReady = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_outValid", 32'(outValid), 0);
        chk("rst_op1", operandOneALU, 0);
        chk("rst_op2", operandTwoALU, 0);
        chk("rst_ctrl", 32'(ControlValueALU), 0);
        chk("rst_dest", 32'(destReg), 0);
        chk("rst_regWrite", 32'(regWrite), 0);
        chk("rst_illegalCount", 32'(illegalCount), 0);
        chk("rst_inReady", 32'(inReady), 1);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic v, input logic ordy, input logic fl);
        instrIn = ins; rsValue = a; rtValue = b; inValid = v; outReady = ordy; flush = fl;
    endtask

    vec_t tbl [20];
    int   exp_cnt;
    logic saw_valid;
    ref_t r;
    logic        m_valid;
    ref_t        m_e;
    int          m_cnt;
    logic        exp_rdy;

    initial begin
        tbl[0]  = '{32'h00221820, 5, 7, 1, 4'b0010, 5, 7, 3, 1, 0};
        tbl[1]  = '{32'h2004FFFF, 0, 9, 1, 4'b0010, 0, 32'hFFFFFFFF, 4, 1, 0};
        tbl[2]  = '{32'h34258000, 32'h12345678, 0, 1, 4'b0001, 32'h12345678, 32'h00008000, 5, 1, 0};
        tbl[3]  = '{32'h00223022, 10, 3, 1, 4'b0110, 10, 3, 6, 1, 0};
        tbl[4]  = '{32'h00023902, 0, 32'h80000000, 1, 4'b1001, 32'h80000000, 4, 7, 1, 0};
        tbl[5]  = '{32'h3C08ABCD, 32'hFFFF, 0, 1, 4'b1000, 0, 32'h0000ABCD, 8, 1, 0};
        tbl[6]  = '{32'h8C29FFFC, 32'h1000, 0, 1, 4'b0010, 32'h1000, 32'hFFFFFFFC, 9, 1, 0};
        tbl[7]  = '{32'hAC290008, 32'h2000, 1, 1, 4'b0010, 32'h2000, 8, 0, 0, 0};
        tbl[8]  = '{32'h10220010, 5, 5, 1, 4'b0110, 5, 5, 0, 0, 0};
        tbl[9]  = '{32'h282AFFFE, 3, 0, 1, 4'b0111, 3, 32'hFFFFFFFE, 10, 1, 0};
        tbl[10] = '{32'h302BF0F0, 32'hFFFFFFFF, 0, 1, 4'b0000, 32'hFFFFFFFF, 32'h0000F0F0, 11, 1, 0};
        tbl[11] = '{32'h00226027, 1, 2, 1, 4'b1010, 1, 2, 12, 1, 0};
        tbl[12] = '{32'h0022682A, 1, 2, 1, 4'b0111, 1, 2, 13, 1, 0};
        tbl[13] = '{32'h00227024, 1, 2, 1, 4'b0000, 1, 2, 14, 1, 0};
        tbl[14] = '{32'h00227825, 1, 2, 1, 4'b0001, 1, 2, 15, 1, 0};
        tbl[15] = '{32'h00228021, 1, 2, 1, 4'b0010, 1, 2, 16, 1, 0};
        tbl[16] = '{32'h00000000, 1, 2, 0, 4'b0000, 0, 0, 0, 0, 0};
        tbl[17] = '{32'hFC000000, 1, 2, 0, 4'b0000, 0, 0, 0, 0, 1};
        tbl[18] = '{32'h00221803, 1, 2, 0, 4'b0000, 0, 0, 0, 0, 1};
        tbl[19] = '{32'h24040005, 32'h10, 0, 1, 4'b0010, 32'h10, 5, 4, 1, 0};

        // Back-to-back decode table with outReady held high.
        do_reset();
        exp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].instr, tbl[i].rs, tbl[i].rt, 1'b1, 1'b1, 1'b0);
            #1;
            chk($sformatf("tbl%0d_inReady", i), 32'(inReady), 1);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_outValid", i), 32'(outValid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_ctrl", i), 32'(ControlValueALU), 32'(tbl[i].ctrl));
                chk($sformatf("tbl%0d_op1", i), operandOneALU, tbl[i].op1);
                chk($sformatf("tbl%0d_op2", i), operandTwoALU, tbl[i].op2);
                chk($sformatf("tbl%0d_regWrite", i), 32'(regWrite), 32'(tbl[i].wr));
                if (tbl[i].wr) chk($sformatf("tbl%0d_dest", i), 32'(destReg), 32'(tbl[i].dest));
            end
            if (tbl[i].ill) exp_cnt++;
            chk($sformatf("tbl%0d_illegalCount", i), 32'(illegalCount), exp_cnt);
        end
        inValid = 1'b0;
        @(posedge clk); #1;
        chk("drain_outValid", 32'(outValid), 0);

        // Stall with a pending instruction, then release.
        do_reset();
        drive(32'h00221820, 5, 7, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("stall_issue_outValid", 32'(outValid), 1);
        drive(32'h00223022, 10, 3, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_inReady", k), 32'(inReady), 0);
            @(posedge clk); #1;
            chk($sformatf("stall%0d_outValid", k), 32'(outValid), 1);
            chk($sformatf("stall%0d_op1", k), operandOneALU, 5);
            chk($sformatf("stall%0d_op2", k), operandTwoALU, 7);
            chk($sformatf("stall%0d_ctrl", k), 32'(ControlValueALU), 32'b0010);
            chk($sformatf("stall%0d_dest", k), 32'(destReg), 3);
        end
        outReady = 1'b1;
        #1;
        chk("release_inReady", 32'(inReady), 1);
        @(posedge clk); #1;
        chk("release_outValid", 32'(outValid), 1);
        chk("release_ctrl", 32'(ControlValueALU), 32'b0110);
        chk("release_op1", operandOneALU, 10);
        chk("release_dest", 32'(destReg), 6);

        // Flush a stalled entry while an illegal instruction is offered.
        drive(32'hFC000000, 0, 0, 1'b1, 1'b0, 1'b1);
        #1;
        chk("flush_inReady", 32'(inReady), 0);
        @(posedge clk); #1;
        chk("flush_outValid", 32'(outValid), 0);
        chk("flush_not_consumed", 32'(illegalCount), 0);
        flush = 1'b0;
        #1;
        chk("postflush_inReady", 32'(inReady), 1);
        @(posedge clk); #1;
        chk("postflush_illegalCount", 32'(illegalCount), 1);
        chk("postflush_outValid", 32'(outValid), 0);

        // Asynchronous reset between edges during a stall.
        drive(32'h00221820, 5, 7, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(32'h00223022, 10, 3, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("arst_pre_outValid", 32'(outValid), 1);
        #3 reset = 1'b1;
        #1;
        chk("arst_outValid", 32'(outValid), 0);
        chk("arst_op1", operandOneALU, 0);
        chk("arst_op2", operandTwoALU, 0);
        chk("arst_ctrl", 32'(ControlValueALU), 0);
        chk("arst_dest", 32'(destReg), 0);
        chk("arst_regWrite", 32'(regWrite), 0);
        chk("arst_illegalCount", 32'(illegalCount), 0);
        chk("arst_inReady", 32'(inReady), 1);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        chk("arst_after_outValid", 32'(outValid), 0);

        // Illegal counter saturation; NOP does not count.
        do_reset();
        drive(32'hFC000000, 0, 0, 1'b1, 1'b1, 1'b0);
        saw_valid = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            if (outValid) saw_valid = 1'b1;
            if (i == 253) chk("sat_254", 32'(illegalCount), 254);
            if (i == 254) chk("sat_255", 32'(illegalCount), 255);
        end
        chk("sat_hold", 32'(illegalCount), 255);
        chk("sat_no_outValid", 32'(saw_valid), 0);
        instrIn = 32'h0;
        @(posedge clk); #1;
        chk("sat_nop_count", 32'(illegalCount), 255);
        chk("sat_nop_outValid", 32'(outValid), 0);

        // Random traffic against the reference model.
        do_reset();
        m_valid = 1'b0; m_e = '0; m_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            drive(gen_instr(), $urandom, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            #1;
            exp_rdy = (!m_valid || outReady) && !flush;
            chk("rnd_inReady", 32'(inReady), 32'(exp_rdy));
            if (flush) m_valid = 1'b0;
            else if (inValid && exp_rdy) begin
                r = ref_dec(instrIn, rsValue, rtValue);
                m_valid = (r.kind == 2'd2);
                if (r.kind == 2'd2) m_e = r;
                if (r.kind == 2'd1 && m_cnt < 255) m_cnt++;
            end else if (m_valid && outReady) m_valid = 1'b0;
            @(posedge clk); #1;
            chk("rnd_outValid", 32'(outValid), 32'(m_valid));
            chk("rnd_illegalCount", 32'(illegalCount), m_cnt);
            if (m_valid) begin
                chk("rnd_ctrl", 32'(ControlValueALU), 32'(m_e.ctrl));
                chk("rnd_op1", operandOneALU, m_e.op1);
                chk("rnd_op2", operandTwoALU, m_e.op2);
                chk("rnd_regWrite", 32'(regWrite), 32'(m_e.wr));
                if (m_e.wr) chk("rnd_dest", 32'(destReg), 32'(m_e.dest));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
